cla_serial_add_ctrl: RTL and testbench



---
 rtl/cla_serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_add_ctrl.sv
// Wide add/subtract built from one 4-bit carry-lookahead slice reused once per nibble,
// LSB first, with the inter-nibble carry held in a register between cycles.

module cla_serial_add_ctrl_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Flat lookahead equations: every carry depends only on g/p and the slice carry-in.
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s = w_p ^ w_c[3:0];
    assign o_c = w_c[4];
endmodule

module cla_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_s;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic           r_cout;
    logic           r_ovf;
    logic           w_accept;
    logic           w_last;
    logic [3:0]     w_sum;
    logic           w_cout;

    cla_serial_add_ctrl_cla4 u_cla (
        .i_a (r_a[4*r_idx +: 4]),
        .i_b (r_b[4*r_idx +: 4]),
        .i_c (r_carry),
        .o_s (w_sum),
        .o_c (w_cout)
    );

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_idx == IW'(NIBBLES - 1));
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1, so the inversion and the +1 are folded in here.
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : Cin;
            r_idx   <= '0;
            r_s     <= '0;
        end else if (r_state == RUN) begin
            r_s[4*r_idx +: 4] <= w_sum;
            r_carry           <= w_cout;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= (r_a[W-1] ~^ r_b[W-1]) & (w_sum[3] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed and random checks of the nibble-serial CLA adder at NIBBLES=4 and NIBBLES=1.

module tb_cla_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Cin, sub;
    logic        in_valid4, out_ready4, in_valid1, out_ready1;
    logic [15:0] A4, B4;
    logic [3:0]  A1, B1;
    logic        in_ready4, out_valid4, Cout4, ovf4, busy4;
    logic        in_ready1, out_valid1, Cout1, ovf1, busy1;
    logic [15:0] S4;
    logic [3:0]  S1;

    logic        sel1;
    logic        o_rdy, o_vld, o_c, o_ov, o_busy;
    logic [15:0] o_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A4), .B(B4), .Cin(Cin), .sub(sub), .out_valid(out_valid4),
        .out_ready(out_ready4), .S(S4), .Cout(Cout4), .ovf(ovf4), .busy(busy4)
    );

    cla_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A1), .B(B1), .Cin(Cin), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready1), .S(S1), .Cout(Cout1), .ovf(ovf1), .busy(busy1)
    );

    always_comb begin
        o_rdy  = sel1 ? in_ready1  : in_ready4;
        o_vld  = sel1 ? out_valid1 : out_valid4;
        o_c    = sel1 ? Cout1      : Cout4;
        o_ov   = sel1 ? ovf1       : ovf4;
        o_busy = sel1 ? busy1      : busy4;
        o_s    = sel1 ? {12'h000, S1} : S4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: W-bit add of A and (possibly inverted) B with carry-in.
    task automatic model(input bit one, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb,
                         output logic [15:0] s, output logic c, output logic ov);
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        int msb;
        mask = one ? 16'h000F : 16'hFFFF;
        msb  = one ? 3 : 15;
        bb   = (sb ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + (sb ? 17'd1 : {16'd0, cin});
        s    = full[15:0] & mask;
        c    = one ? full[4] : full[16];
        ov   = (a[msb] == bb[msb]) && (s[msb] != a[msb]);
    endtask

    // Accept one operation and wait for out_valid; checks handshake, latency and result.
    task automatic issue(input bit one, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo, input string tag);
        int lat;
        sel1 = one;
        @(negedge clk);
        if (one) begin A1 = a[3:0]; B1 = b[3:0]; in_valid1 = 1'b1; end
        else     begin A4 = a;      B4 = b;      in_valid4 = 1'b1; end
        Cin = cin; sub = sb;
        #1 check({tag, ".in_ready_idle"}, o_rdy, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        // Scramble operands after the accept edge; they must not leak into the result.
        A4 = 16'($urandom); B4 = 16'($urandom); A1 = 4'($urandom); B1 = 4'($urandom);
        Cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_vld) begin lat = i; break; end
            check({tag, ".in_ready_run"}, o_rdy, 0);
            check({tag, ".busy_run"}, o_busy, 1);
        end
        check({tag, ".latency"}, lat, one ? 1 : 4);
        check({tag, ".S"}, o_s, es);
        check({tag, ".Cout"}, o_c, ec);
        check({tag, ".ovf"}, o_ov, eo);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        if (sel1) out_ready1 = 1'b1; else out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0; out_ready4 = 1'b0;
        check({tag, ".valid_drop"}, o_vld, 0);
        check({tag, ".in_ready_back"}, o_rdy, 1);
    endtask

    task automatic do_op(input bit one, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo, input string tag);
        issue(one, a, b, cin, sb, es, ec, eo, tag);
        release_out(tag);
    endtask

    initial begin
        logic [15:0] ra, rb, es, hs;
        logic        rc, rs, ec, eo, hc, ho;

        sel1 = 1'b0;
        rst_n = 1'b0; in_valid4 = 0; in_valid1 = 0; out_ready4 = 0; out_ready1 = 0;
        A4 = '0; B4 = '0; A1 = '0; B1 = '0; Cin = 0; sub = 0;
        #2;
        check("rst.in_ready", in_ready4, 1);
        check("rst.out_valid", out_valid4, 0);
        check("rst.busy", busy4, 0);
        check("rst.S", S4, 0);
        check("rst.Cout", Cout4, 0);
        check("rst.ovf", ovf4, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        do_op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "add_wrap");
        do_op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "ovf_pos");
        do_op(0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, "ovf_neg");
        do_op(0, 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, "sub_borrow");
        do_op(0, 16'h1234, 16'h0234, 0, 1, 16'h1000, 1, 0, "sub_noborrow");
        do_op(0, 16'h0F0F, 16'h00F1, 1, 0, 16'h1001, 0, 0, "add_cin");

        // Backpressure: result held, new requests ignored while out_ready is low.
        issue(0, 16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, "bp");
        @(negedge clk);
        A4 = 16'h0101; B4 = 16'h0202; in_valid4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp.valid_hold", out_valid4, 1);
            check("bp.in_ready_low", in_ready4, 0);
            check("bp.S_hold", S4, 16'h3333);
            check("bp.Cout_hold", Cout4, 0);
            check("bp.ovf_hold", ovf4, 0);
        end
        in_valid4 = 1'b0;
        release_out("bp");
        check("bp.S_kept_idle", S4, 16'h3333);

        // Reset in the middle of RUN (idx==2).
        @(negedge clk);
        A4 = 16'hAAAA; B4 = 16'h5555; Cin = 1; sub = 0; in_valid4 = 1'b1;
        @(posedge clk); #1 in_valid4 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("midrst.busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", in_ready4, 1);
        check("midrst.out_valid", out_valid4, 0);
        check("midrst.busy", busy4, 0);
        check("midrst.S", S4, 0);
        check("midrst.Cout", Cout4, 0);
        check("midrst.ovf", ovf4, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst.no_valid", out_valid4, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst.idle_after", out_valid4, 0);
        end
        do_op(0, 16'h0003, 16'h0004, 0, 0, 16'h0007, 0, 0, "after_rst");

        // NIBBLES=1 directed corners.
        do_op(1, 16'h000F, 16'h0001, 0, 0, 16'h0000, 1, 0, "n1_wrap");
        do_op(1, 16'h0007, 16'h0001, 0, 0, 16'h0008, 0, 1, "n1_ovf");
        do_op(1, 16'h0003, 16'h0005, 1, 1, 16'h000E, 0, 0, "n1_sub");

        // Spot-check the reference model against hand values before trusting it.
        model(0, 16'h0005, 16'h0007, 1, 1, hs, hc, ho);
        check("model.sub_S", hs, 16'hFFFE);
        check("model.sub_C", hc, 0);
        model(1, 16'h0008, 16'h0008, 0, 0, hs, hc, ho);
        check("model.n1_ov", {hs, hc, ho}, {16'h0000, 1'b1, 1'b1});

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            model(0, ra, rb, rc, rs, es, ec, eo);
            do_op(0, ra, rb, rc, rs, es, ec, eo, "rnd4");
        end
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            model(1, ra, rb, rc, rs, es, ec, eo);
            do_op(1, ra, rb, rc, rs, es, ec, eo, "rnd1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
